// File: rtl/key_pio_sequencer.sv
// key_pio_sequencer
//   Avalon-MM master that owns a 4-bit key PIO slave. After reset it programs
//   the interrupt mask and clears the edge-capture register. On request it
//   reloads the mask. On pio_irq it reads edge capture (addr 3), then the key
//   level (addr 0), and then clears the capture. Non-empty events are queued
//   as {level, edges} in a small FIFO for the downstream consumer.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   pio_address/...     : registered Avalon-MM master bus (idle: cs=0, write_n=1)
//   pio_readdata        : slave read data, valid one cycle after the address
//   pio_irq             : PIO interrupt (edge capture & mask)
//   cfg_mask, cfg_load  : mask reload request (the last pulse before the write wins)
//   evt_valid/data/ready: event FIFO head, popped on valid & ready
//   fifo_count          : FIFO occupancy
//   busy                : FSM is outside IDLE
module key_pio_sequencer #(
  parameter logic [3:0] INIT_MASK  = 4'hF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [1:0]                    pio_address,
  output logic                          pio_chipselect,
  output logic                          pio_write_n,
  output logic [31:0]                   pio_writedata,
  input  logic [31:0]                   pio_readdata,
  input  logic                          pio_irq,
  input  logic [3:0]                    cfg_mask,
  input  logic                          cfg_load,
  output logic                          evt_valid,
  output logic [7:0]                    evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_INIT_MASK = 3'd0,
    S_INIT_CLR  = 3'd1,
    S_IDLE      = 3'd2,
    S_CFG       = 3'd3,
    S_ISSUE_E   = 3'd4,
    S_ISSUE_L   = 3'd5,
    S_CLEAR     = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic          armed_q;
  logic          cfg_pend_q, cfg_pend_d;
  logic [3:0]    cfg_mask_q, cfg_mask_d;
  logic [3:0]    edges_q, edges_d;
  logic          cs_q, cs_d;
  logic          wn_q, wn_d;
  logic [1:0]    addr_q, addr_d;
  logic [3:0]    wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_s, pop_s;
  logic          rdata_unused;

  assign rdata_unused = ^pio_readdata[31:4];

  // Mask request latch: a new pulse overrides both the flag and the mask.
  always_comb begin
    cfg_pend_d = cfg_pend_q;
    cfg_mask_d = cfg_mask_q;
    if (cfg_load) begin
      cfg_pend_d = 1'b1;
      cfg_mask_d = cfg_mask;
    end else if (state_q == S_CFG) begin
      cfg_pend_d = 1'b0;
    end else begin
      cfg_pend_d = cfg_pend_q;
    end
  end

  // Next-state logic. The first cycle after reset only arms the bus registers.
  // The sequencer stays in INIT_MASK for that cycle, so the mask write appears
  // on the bus in the first cycle after that arming edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_MASK: begin
        if (armed_q) state_d = S_INIT_CLR;
        else         state_d = S_INIT_MASK;
      end
      S_INIT_CLR:  state_d = S_IDLE;
      S_IDLE: begin
        // cfg_load is included directly so a pulse coinciding with an IRQ still wins.
        if (cfg_pend_q || cfg_load)                state_d = S_CFG;
        else if (pio_irq && (count_q < FULL_CNT))  state_d = S_ISSUE_E;
        else                                       state_d = S_IDLE;
      end
      S_CFG:       state_d = S_IDLE;
      S_ISSUE_E:   state_d = S_ISSUE_L;
      S_ISSUE_L:   state_d = S_CLEAR;
      S_CLEAR:     state_d = S_IDLE;
      default:     state_d = S_INIT_MASK;
    endcase
  end

  // Bus values for the state being entered. These are registered, so the bus
  // always reflects the current state.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 2'd0;
    wdata_d = 4'h0;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_INIT_MASK: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd2; wdata_d = INIT_MASK;  end
      S_INIT_CLR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd3; wdata_d = 4'hF;       end
      S_CFG:       begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd2; wdata_d = cfg_mask_d; end
      S_ISSUE_E:   begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 2'd3; wdata_d = 4'h0;       end
      S_ISSUE_L:   begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 2'd0; wdata_d = 4'h0;       end
      S_CLEAR:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd3; wdata_d = 4'h0;       end
      default:     begin cs_d = 1'b0; wn_d = 1'b1; addr_d = 2'd0; wdata_d = 4'h0;       end
    endcase
  end

  // Edge capture: during ISSUE_L, the read data holds the capture read issued in ISSUE_E.
  always_comb begin
    edges_d = edges_q;
    if (state_q == S_ISSUE_L) edges_d = pio_readdata[3:0];
    else                      edges_d = edges_q;
  end

  // FIFO control: during CLEAR, the read data holds the key level.
  always_comb begin
    push_s  = (state_q == S_CLEAR) && (edges_q != 4'h0);
    pop_s   = (count_q != '0) && evt_ready;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FSM, configuration and bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT_MASK;
      armed_q    <= 1'b0;
      cfg_pend_q <= 1'b0;
      cfg_mask_q <= 4'h0;
      edges_q    <= 4'h0;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      addr_q     <= 2'd0;
      wdata_q    <= 4'h0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      cfg_pend_q <= cfg_pend_d;
      cfg_mask_q <= cfg_mask_d;
      edges_q    <= edges_d;
      cs_q       <= cs_d;
      wn_q       <= wn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {pio_readdata[3:0], edges_q};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_address    = addr_q;
  assign pio_writedata  = {28'h0000000, wdata_q};
  assign busy           = busy_q;
  assign evt_valid      = (count_q != '0);
  assign evt_data       = mem_q[rd_ptr_q];
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_key_pio_sequencer.sv
module tb_key_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic [3:0]  cfg_mask = 4'h0;
  logic        cfg_load = 1'b0;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_pio_sequencer #(.INIT_MASK(4'hF), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .cfg_mask(cfg_mask), .cfg_load(cfg_load),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .fifo_count(fifo_count), .busy(busy)
  );

  // Key PIO slave model: falling-edge capture, any write to addr 3 clears all capture bits.
  logic [3:0]  keys = 4'hF;
  logic [3:0]  keys_prev = 4'hF;
  logic [3:0]  m_cap = 4'h0;
  logic [3:0]  m_mask = 4'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        spur = 1'b0;   // injected IRQ with nothing captured
  logic [7:0]  log_q[$];      // bus accesses: {write_n, 0, addr, data[3:0]}

  assign pio_readdata = m_rdata;
  assign pio_irq      = (|(m_cap & m_mask)) | spur;

  always @(posedge clk) begin
    keys_prev <= keys;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) m_cap <= 4'h0;
    else                                                        m_cap <= m_cap | (keys_prev & ~keys);
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) m_mask <= pio_writedata[3:0];
    if (pio_chipselect && pio_write_n) begin
      case (pio_address)
        2'd0:    m_rdata <= {28'h0000000, keys};
        2'd2:    m_rdata <= {28'h0000000, m_mask};
        2'd3:    m_rdata <= {28'h0000000, m_cap};
        default: m_rdata <= 32'h0;
      endcase
    end
    if (pio_chipselect) log_q.push_back({pio_write_n, 1'b0, pio_address, pio_writedata[3:0]});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare the bus log against up to four expected entries packed MSB-first.
  task automatic chk_log(input string tag, input int n, input logic [31:0] exp);
    logic [7:0] got;
    check({tag, " count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < log_q.size()) ? log_q[i] : 8'h00;
      check({tag, " entry"}, 32'(got), 32'(exp[31-8*i -: 8]));
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    check({tag, " cs"},    32'(pio_chipselect), 32'd0);
    check({tag, " wn"},    32'(pio_write_n),    32'd1);
    check({tag, " addr"},  32'(pio_address),    32'd0);
    check({tag, " wdata"}, pio_writedata,       32'd0);
  endtask

  initial begin
    // Reset values and INIT sequence.
    tick(2);
    chk_idle_bus("reset");
    check("reset evt_valid", 32'(evt_valid), 32'd0);
    check("reset count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    log_q.delete();
    tick(2);
    check("init busy c2", 32'(busy), 32'd1);
    tick(1);
    check("init busy c3", 32'(busy), 32'd0);
    tick(4);
    chk_log("init log", 2, 32'h2F3F_0000);
    check("init count", 32'(fifo_count), 32'd0);

    // Key 1 falling edge, level 1101.
    log_q.delete();
    keys = 4'b1101;
    tick(1);
    check("svc irq T", 32'(pio_irq), 32'd1);
    tick(3);
    check("svc valid T+3", 32'(evt_valid), 32'd0);
    tick(1);
    check("svc valid T+4", 32'(evt_valid), 32'd1);
    check("svc data", 32'(evt_data), 32'hD2);
    check("svc irq T+4", 32'(pio_irq), 32'd0);
    check("svc count", 32'(fifo_count), 32'd1);
    chk_log("svc log", 3, 32'hB080_3000);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("svc pop count", 32'(fifo_count), 32'd0);
    keys = 4'hF;
    tick(2);

    // cfg_load in the same cycle the IRQ is visible: mask write comes first.
    log_q.delete();
    keys = 4'b1110;
    tick(1);
    check("cfg irq", 32'(pio_irq), 32'd1);
    cfg_mask = 4'h5;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    tick(6);
    chk_log("cfg log", 4, 32'h25B0_8030);
    check("cfg data", 32'(evt_data), 32'hE1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    keys = 4'hF;
    tick(1);
    log_q.delete();
    keys = 4'b1101;
    tick(1);
    check("masked irq", 32'(pio_irq), 32'd0);
    tick(6);
    check("masked count", 32'(fifo_count), 32'd0);
    check("masked log", 32'(log_q.size()), 32'd0);
    keys = 4'hF;
    tick(1);

    // Fill the FIFO. The first service also picks up the masked key-1 capture.
    for (int i = 0; i < 4; i++) begin
      keys = 4'b1110;
      tick(6);
      keys = 4'hF;
      tick(1);
    end
    check("full count", 32'(fifo_count), 32'd4);
    check("full head", 32'(evt_data), 32'hE3);
    log_q.delete();
    keys = 4'b1110;
    tick(7);
    check("full irq held", 32'(pio_irq), 32'd1);
    check("full no bus", 32'(log_q.size()), 32'd0);
    check("full busy", 32'(busy), 32'd0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("pop count", 32'(fifo_count), 32'd3);
    check("pop next head", 32'(evt_data), 32'hE1);
    tick(1);
    check("resume cs", 32'(pio_chipselect), 32'd1);
    check("resume addr", 32'(pio_address), 32'd3);
    check("resume wn", 32'(pio_write_n), 32'd1);
    tick(3);
    check("refill count", 32'(fifo_count), 32'd4);
    check("refill irq", 32'(pio_irq), 32'd0);
    evt_ready = 1'b1;
    tick(4);
    evt_ready = 1'b0;
    check("drain count", 32'(fifo_count), 32'd0);
    keys = 4'hF;
    tick(1);

    // Spurious IRQ: capture reads zero, the clear write still occurs, no push.
    log_q.delete();
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(5);
    chk_log("spur log", 3, 32'hB080_3000);
    check("spur count", 32'(fifo_count), 32'd0);
    check("spur valid", 32'(evt_valid), 32'd0);

    // Reset asserted in ISSUE_L.
    keys = 4'b1110;
    tick(6);
    keys = 4'hF;
    tick(1);
    check("pre-rst count", 32'(fifo_count), 32'd1);
    keys = 4'b1110;
    tick(3);
    check("issue_l cs", 32'(pio_chipselect), 32'd1);
    check("issue_l addr", 32'(pio_address), 32'd0);
    reset = 1'b1;
    #1;
    chk_idle_bus("mid-rst");
    check("mid-rst count", 32'(fifo_count), 32'd0);
    check("mid-rst valid", 32'(evt_valid), 32'd0);
    keys = 4'hF;
    tick(2);
    log_q.delete();
    reset = 1'b0;
    tick(6);
    chk_log("reinit log", 2, 32'h2F3F_0000);
    check("reinit count", 32'(fifo_count), 32'd0);
    check("reinit valid", 32'(evt_valid), 32'd0);
    check("reinit busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
